// File: rtl/change_dispenser_if.sv
// Bundle of signals between the vending controller/coin ejector and the change dispenser.
// The master side drives the dispense request and the ejector acknowledge; the slave side is the dispenser.
interface change_dispenser_if;
  logic       dispense;
  logic [4:0] change;
  logic       coin_ack;
  logic       fault_clr;
  logic       eject_q;
  logic       eject_d;
  logic       eject_n;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       fault;
  logic [4:0] remaining;

  modport master (
    output dispense, change, coin_ack, fault_clr,
    input  eject_q, eject_d, eject_n, busy, done, overrun, fault, remaining
  );

  modport slave (
    input  dispense, change, coin_ack, fault_clr,
    output eject_q, eject_d, eject_n, busy, done, overrun, fault, remaining
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a change amount as a greedy quarter/dime/nickel sequence, one coin per req/ack handshake.
// All outputs come straight from registers that are loaded alongside the state transition.
module change_dispenser #(
  parameter int VAL_Q       = 25,
  parameter int VAL_D       = 10,
  parameter int VAL_N       = 5,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 2
) (
  input logic              clk,
  input logic              reset,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE, FAULT} stateT;

  localparam logic [1:0] SEL_Q = 2'd0;
  localparam logic [1:0] SEL_D = 2'd1;
  localparam logic [1:0] SEL_N = 2'd2;

  localparam logic [4:0] COIN_Q       = 5'(VAL_Q);
  localparam logic [4:0] COIN_D       = 5'(VAL_D);
  localparam logic [4:0] COIN_N       = 5'(VAL_N);
  localparam logic [4:0] TIMEOUT_LAST = 5'(ACK_TIMEOUT - 1);
  localparam logic [4:0] GAP_LAST     = 5'(GAP_CYCLES - 1);

  stateT      r_state;
  logic [4:0] r_remaining;
  logic [4:0] r_timer;
  logic [1:0] r_coinSel;
  logic [2:0] r_eject;
  logic       r_busy;
  logic       r_done;
  logic       r_overrun;
  logic       r_fault;

  function automatic logic [4:0] coinValue(input logic [1:0] sel);
    case (sel)
      SEL_Q:   return COIN_Q;
      SEL_D:   return COIN_D;
      default: return COIN_N;
    endcase
  endfunction

  function automatic logic [2:0] ejectLines(input logic [1:0] sel);
    case (sel)
      SEL_Q:   return 3'b100;
      SEL_D:   return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Each branch loads the outputs for the state it is entering, so outputs track r_state with no input paths.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_timer     <= '0;
      r_coinSel   <= SEL_Q;
      r_eject     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_eject   <= '0;
      r_overrun <= bus.dispense && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (bus.dispense) begin
            r_remaining <= bus.change;
            r_busy      <= 1'b1;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          r_timer <= '0;
          if (r_remaining == 5'd0) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_remaining >= COIN_Q) begin
            r_coinSel <= SEL_Q;
            r_eject   <= ejectLines(SEL_Q);
            r_state   <= EJECT;
          end else if (r_remaining >= COIN_D) begin
            r_coinSel <= SEL_D;
            r_eject   <= ejectLines(SEL_D);
            r_state   <= EJECT;
          end else if (r_remaining >= COIN_N) begin
            r_coinSel <= SEL_N;
            r_eject   <= ejectLines(SEL_N);
            r_state   <= EJECT;
          end else begin
            r_fault <= 1'b1;
            r_state <= FAULT;
          end
        end
        EJECT: begin
          // An ack arriving in the last timeout cycle still counts as a paid coin.
          if (bus.coin_ack) begin
            r_remaining <= r_remaining - coinValue(r_coinSel);
            r_timer     <= '0;
            r_state     <= GAP;
          end else if (r_timer == TIMEOUT_LAST) begin
            r_fault <= 1'b1;
            r_state <= FAULT;
          end else begin
            r_timer <= r_timer + 5'd1;
            r_eject <= ejectLines(r_coinSel);
          end
        end
        GAP: begin
          if (r_timer == GAP_LAST) begin
            r_state <= SELECT;
          end else begin
            r_timer <= r_timer + 5'd1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        FAULT: begin
          if (bus.fault_clr) begin
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.eject_q   = r_eject[2];
  assign bus.eject_d   = r_eject[1];
  assign bus.eject_n   = r_eject[0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.overrun   = r_overrun;
  assign bus.fault     = r_fault;
  assign bus.remaining = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a greedy coin-list model predicts each eject, the ending and its timing.
// The bench plays the coin ejector, acking each request after a random (or forced) delay, or never.
module tb_change_dispenser;

  localparam int VQ      = 25;
  localparam int VD      = 10;
  localparam int VN      = 5;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  change_dispenser_if bus ();

  change_dispenser #(
    .VAL_Q(VQ), .VAL_D(VD), .VAL_N(VN), .ACK_TIMEOUT(TIMEOUT), .GAP_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [2:0] ejectVec;
  assign ejectVec = {bus.eject_q, bus.eject_d, bus.eject_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents one dispense strobe; returns on the following falling edge.
  task automatic applyStimulus(input logic [4:0] amount);
    bus.dispense = 1'b1;
    bus.change   = amount;
    @(negedge clk);
    bus.dispense = 1'b0;
    bus.change   = $urandom_range(0, 31);
  endtask

  task automatic clearFault();
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    checkOutput("faultCleared", bus.fault, 0);
    checkOutput("idleAfterClear", bus.busy, 0);
  endtask

  // Waits for an eject, done or fault; the cycle count is checked against the expected latency.
  task automatic waitEvent(input string tag, input int expLatency);
    int w;
    w = 0;
    while (ejectVec == 3'b000 && !bus.done && !bus.fault && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput(tag, w, expLatency);
  endtask

  // One full transaction; noAckIdx picks a coin the ejector never acks, ackDelay<0 means random.
  task automatic runPayout(input logic [4:0] amount, input int noAckIdx, input bit doOverrun, input int ackDelay);
    logic [2:0] coins[$];
    int         values[$];
    int         rem;
    int         d;
    int         h;
    rem = amount;
    while (rem >= VN) begin
      if (rem >= VQ) begin coins.push_back(3'b100); values.push_back(VQ); rem -= VQ; end
      else if (rem >= VD) begin coins.push_back(3'b010); values.push_back(VD); rem -= VD; end
      else begin coins.push_back(3'b001); values.push_back(VN); rem -= VN; end
    end
    rem = amount;
    applyStimulus(amount);
    checkOutput("busyAfterDispense", bus.busy, 1);
    for (int k = 0; k < coins.size(); k++) begin
      waitEvent("ejectLatency", (k == 0) ? 1 : 3);
      checkOutput("ejectSelect", ejectVec, coins[k]);
      if (k == noAckIdx) begin
        h = 1;
        while (h < 40) begin
          @(negedge clk);
          if (ejectVec == 3'b000) break;
          h++;
        end
        checkOutput("timeoutLength", h, TIMEOUT);
        checkOutput("timeoutFault", bus.fault, 1);
        checkOutput("faultRemaining", bus.remaining, rem);
        clearFault();
        return;
      end
      d = (ackDelay >= 0) ? ackDelay : $urandom_range(0, 6);
      if (doOverrun && k == 0 && d < 2) d = 2;
      for (int j = 0; j < d; j++) begin
        if (doOverrun && k == 0 && j == 0) bus.dispense = 1'b1;
        @(negedge clk);
        if (doOverrun && k == 0 && j == 0) begin
          bus.dispense = 1'b0;
          checkOutput("overrunPulse", bus.overrun, 1);
        end
        checkOutput("ejectHold", ejectVec, coins[k]);
      end
      bus.coin_ack = 1'b1;
      @(negedge clk);
      bus.coin_ack = 1'b0;
      checkOutput("ejectDrop", ejectVec, 0);
      rem -= values[k];
    end
    waitEvent("endLatency", (coins.size() == 0) ? 1 : 3);
    if (rem == 0) begin
      checkOutput("donePulse", bus.done, 1);
      checkOutput("noFault", bus.fault, 0);
      @(negedge clk);
      checkOutput("doneOneCycle", bus.done, 0);
      checkOutput("busyDropped", bus.busy, 0);
      checkOutput("noOverrunLeft", bus.overrun, 0);
    end else begin
      checkOutput("residualFault", bus.fault, 1);
      checkOutput("residualRemaining", bus.remaining, rem);
      checkOutput("residualNoDone", bus.done, 0);
      clearFault();
    end
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    reset         = 1'b1;
    bus.dispense  = 1'b0;
    bus.change    = '0;
    bus.coin_ack  = 1'b0;
    bus.fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {ejectVec, bus.busy, bus.done, bus.overrun, bus.fault, bus.remaining}, 0);
    reset = 1'b0;
    @(negedge clk);

    runPayout(5'd20, -1, 1'b0, 1);
    runPayout(5'd15, -1, 1'b0, -1);
    runPayout(5'd0, -1, 1'b0, -1);
    runPayout(5'd20, 0, 1'b0, -1);
    runPayout(5'd7, -1, 1'b0, -1);
    runPayout(5'd31, -1, 1'b0, -1);
    runPayout(5'd25, -1, 1'b0, TIMEOUT - 1);
    runPayout(5'd30, -1, 1'b1, -1);

    // Stray handshake inputs while idle must be ignored.
    bus.coin_ack  = 1'b1;
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.coin_ack  = 1'b0;
    bus.fault_clr = 1'b0;
    checkOutput("idleIgnoresStray", {ejectVec, bus.busy, bus.fault}, 0);

    for (int i = 0; i < 30; i++) begin
      runPayout(5'($urandom_range(0, 31)),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1,
                ($urandom_range(0, 3) == 0), -1);
    end

    applyStimulus(5'd30);
    @(negedge clk);
    checkOutput("quarterBeforeReset", ejectVec, 3'b100);
    #2 reset = 1'b1;
    #1 checkOutput("asyncResetOutputs", {ejectVec, bus.busy, bus.done, bus.overrun, bus.fault, bus.remaining}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterReset", {ejectVec, bus.busy}, 0);
    runPayout(5'd10, -1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
